xvc_shift_sched: RTL and testbench
==================================

# xvc_shift_sched

Sequences multi-word XVC `shift:` commands onto the 32-bit JTAG shift engine. The block accepts one command with a bit count, reads TMS/TDI words from the vector buffer, and splits the command into chunks of up to 32 bits. It starts the engine once per chunk, waits for the engine's done strobe, and writes each captured TDO word back to the result buffer. It sits between the AXI-Lite/command front end and the JTAG shift engine.

## Interface
- `C_MAX_WORDS`, 64: buffer depth in 32-bit words; the maximum command is C_MAX_WORDS*32 bits.
- `C_ADDR_W`, 6: buffer address width; must satisfy 2**C_ADDR_W >= C_MAX_WORDS.
- `C_TIMEOUT_CYCLES`, 65535: engine-done watchdog limit in clk_i cycles.
- `clk_i` in 1: single clock.
- `reset_ni` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: high only in IDLE; a command is accepted when valid&&ready.
- `cmd_nbits_i` in 32: total bits to shift.
- `rd_addr_o` out C_ADDR_W: vector buffer word address.
- `rd_tms_i` in 32: TMS word, valid 1 cycle after rd_addr_o.
- `rd_tdi_i` in 32: TDI word, valid 1 cycle after rd_addr_o.
- `wr_en_o` out 1: TDO result write strobe.
- `wr_addr_o` out C_ADDR_W: result word address.
- `wr_data_o` out 32: captured TDO word.
- `eng_en_o` out 1: engine enable; the engine starts on its rising edge.
- `eng_length_o` out 32: chunk bit length, 1..32.
- `eng_tms_o` out 32: chunk TMS vector.
- `eng_tdi_o` out 32: chunk TDI vector.
- `eng_tdo_i` in 32: engine TDO vector, sampled in the cycle eng_done_i is high.
- `eng_done_i` in 1: one-cycle engine completion pulse.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle command-complete pulse.
- `err_o` out 1: valid with done_o; high means the command was rejected or timed out.

## Operation
- The FSM has the states IDLE, FETCH, LOAD, KICK, WAIT, STORE and FINISH.
- IDLE: on command accept, latch `rem = cmd_nbits_i` and set `word = 0`.
  - If `cmd_nbits_i == 0`: go to FINISH with err=0. No engine activity, no writes.
  - If `cmd_nbits_i > C_MAX_WORDS*32`: go to FINISH with err=1. No engine activity, no writes.
  - Otherwise: go to FETCH.
- FETCH: drive `rd_addr_o = word`. Next state is LOAD.
- LOAD: register rd_tms_i/rd_tdi_i into eng_tms_o/eng_tdi_o. Set `eng_length_o = (rem >= 32) ? 32 : rem`. Next state is KICK.
- KICK: assert eng_en_o. Next state is WAIT.
- WAIT: hold eng_en_o=1 and keep the eng_* vectors stable until eng_done_i.
  - On eng_done_i: capture eng_tdo_i into wr_data_o and go to STORE.
- STORE: eng_en_o=0, wr_en_o=1 for one cycle with `wr_addr_o = word`.
  - Update `rem -= eng_length_o` and `word += 1`.
  - If the updated rem is 0, go to FINISH; otherwise go to FETCH.
  - This guarantees at least 3 low cycles of eng_en_o between chunks, so the engine always sees a fresh rising edge.
- FINISH: done_o=1 and err_o=latched error for one cycle. Next state is IDLE.
- Arithmetic:
  - rem is 32-bit unsigned and never underflows, because the chunk length is always <= rem.
  - word counts 0..C_MAX_WORDS-1 and never wraps within a legal command.
- cmd_valid_i while busy is ignored, since cmd_ready_o=0.
- An eng_done_i pulse outside WAIT is ignored.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - The state is IDLE.
  - All outputs are 0, except cmd_ready_o=1 once reset_ni deasserts.
- Reset mid-command returns the block to IDLE immediately. eng_en_o drops asynchronously, and no done_o pulse is issued.
- Per-chunk overhead outside engine time is 5 cycles: FETCH, LOAD, KICK, STORE, plus the done-sample cycle in WAIT.
- FINISH adds 1 cycle per command.
- An N-chunk command completes ceil(nbits/32)*5 + sum(engine latencies) + 2 cycles after accept.
- The zero-bit and oversize cases complete with done_o exactly 2 cycles after accept.
- wr_en_o follows eng_done_i by exactly 1 cycle.

## Configuration
- `XVC_SHIFT_TIMEOUT_EN` defined:
  - A 32-bit watchdog counter clears on KICK and increments in WAIT.
  - When it reaches C_TIMEOUT_CYCLES: drop eng_en_o, skip the remaining chunks, do not write the pending word, and go to FINISH with err=1.
- Not defined: no counter exists, and WAIT waits indefinitely for eng_done_i.

## Test plan
- nbits=32, TMS=0x0000_0001, TDI=0xA5A5_A5A5, engine model returns 0x1234_5678 -> one engine start with length 32, one write of 0x1234_5678 at addr 0, done_o=1, err_o=0.
- nbits=70 -> three chunks with lengths 32, 32, 6; writes at addr 0, 1, 2; eng_en_o low between chunks; done_o once.
- nbits=0 -> done_o=1, err_o=0 two cycles after accept; eng_en_o and wr_en_o never asserted.
- nbits = C_MAX_WORDS*32+1 -> done_o=1 and err_o=1 with no engine start; nbits = C_MAX_WORDS*32 -> C_MAX_WORDS chunks, err_o=0.
- With XVC_SHIFT_TIMEOUT_EN, C_TIMEOUT_CYCLES=100, engine never responds -> eng_en_o drops, done_o=1 and err_o=1 after 100 WAIT cycles, no write. Without the macro, the block stays busy.
- Assert reset_ni low mid-WAIT of a 3-chunk command -> all outputs 0 asynchronously, no done_o. The next command then runs normally.

Source files
------------

// File: rtl/xvc_shift_sched_if.sv
// xvc_shift_sched_if: command, vector-buffer, result-buffer and shift-engine
// signals of the XVC shift scheduler, bundled so the scheduler and its
// environment connect through one port.
//   slave  : scheduler view
//   master : environment view (front end, buffers, engine)
interface xvc_shift_sched_if #(
    parameter int C_ADDR_W = 6
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [31:0]         cmd_nbits_i;
    logic [C_ADDR_W-1:0] rd_addr_o;
    logic [31:0]         rd_tms_i;
    logic [31:0]         rd_tdi_i;
    logic                wr_en_o;
    logic [C_ADDR_W-1:0] wr_addr_o;
    logic [31:0]         wr_data_o;
    logic                eng_en_o;
    logic [31:0]         eng_length_o;
    logic [31:0]         eng_tms_o;
    logic [31:0]         eng_tdi_o;
    logic [31:0]         eng_tdo_i;
    logic                eng_done_i;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport slave (
        input  cmd_valid_i, cmd_nbits_i, rd_tms_i, rd_tdi_i, eng_tdo_i, eng_done_i,
        output cmd_ready_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, eng_en_o,
               eng_length_o, eng_tms_o, eng_tdi_o, busy_o, done_o, err_o
    );

    modport master (
        output cmd_valid_i, cmd_nbits_i, rd_tms_i, rd_tdi_i, eng_tdo_i, eng_done_i,
        input  cmd_ready_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, eng_en_o,
               eng_length_o, eng_tms_o, eng_tdi_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/xvc_shift_sched.sv
// xvc_shift_sched: splits one XVC shift command into 32-bit chunks, feeds
// each chunk to the JTAG shift engine and stores the captured TDO words.
// Optional feature macro: XVC_SHIFT_TIMEOUT_EN enables an engine-done
// watchdog that aborts the command with an error after C_TIMEOUT_CYCLES.
module xvc_shift_sched #(
    parameter int C_MAX_WORDS      = 64,
    parameter int C_ADDR_W         = 6,
    parameter int C_TIMEOUT_CYCLES = 65535
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    xvc_shift_sched_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_KICK   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    localparam logic [31:0] MAX_BITS = 32'(C_MAX_WORDS * 32);

    // Engine chunk length: at most one full word of bits.
    function automatic logic [31:0] chunk_len(input logic [31:0] bits_left);
        return (bits_left >= 32'd32) ? 32'd32 : bits_left;
    endfunction

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [31:0]         rem;
    logic [31:0]         rem_after;
    logic [C_ADDR_W-1:0] word;
    logic                err_q;
    logic [31:0]         len_q;
    logic [31:0]         tms_q;
    logic [31:0]         tdi_q;
    logic [31:0]         tdo_q;
    logic                accept;
    logic                timeout_hit;

    assign accept    = bus.cmd_valid_i && (state == S_IDLE);
    assign rem_after = rem - len_q;

`ifdef XVC_SHIFT_TIMEOUT_EN
    logic [31:0] wdog;

    // Watchdog: restarts at each engine kick, counts cycles spent waiting.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            wdog <= '0;
        else if (state == S_KICK)
            wdog <= '0;
        else if (state == S_WAIT)
            wdog <= wdog + 32'd1;
    end

    // A done strobe in the final allowed cycle still wins over the abort.
    assign timeout_hit = (state == S_WAIT) && !bus.eng_done_i &&
                         ((wdog + 32'd1) >= 32'(C_TIMEOUT_CYCLES));
`else
    // The watchdog limit has no effect in this build.
    logic unused_timeout;
    assign unused_timeout = (C_TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Next-state selection for the chunk sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.cmd_nbits_i == 32'd0 || bus.cmd_nbits_i > MAX_BITS)
                        state_nxt = S_FINISH;
                    else
                        state_nxt = S_FETCH;
                end
            end
            S_FETCH:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_KICK;
            S_KICK:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done_i)
                    state_nxt = S_STORE;
                else if (timeout_hit)
                    state_nxt = S_FINISH;
            end
            S_STORE:  state_nxt = (rem_after == 32'd0) ? S_FINISH : S_FETCH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Command bookkeeping: bits left, current word and the error flag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rem   <= '0;
            word  <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            rem   <= bus.cmd_nbits_i;
            word  <= '0;
            err_q <= (bus.cmd_nbits_i > MAX_BITS);
        end else if (state == S_STORE) begin
            rem   <= rem_after;
            word  <= word + C_ADDR_W'(1);
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    // Chunk vectors are loaded from the buffer read data and held until the next LOAD.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            len_q <= '0;
            tms_q <= '0;
            tdi_q <= '0;
        end else if (state == S_LOAD) begin
            len_q <= chunk_len(rem);
            tms_q <= bus.rd_tms_i;
            tdi_q <= bus.rd_tdi_i;
        end
    end

    // Captured TDO word, taken only when the engine reports done while waited on.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            tdo_q <= '0;
        else if (state == S_WAIT && bus.eng_done_i)
            tdo_q <= bus.eng_tdo_i;
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign bus.cmd_ready_o  = reset_ni && (state == S_IDLE);
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.rd_addr_o    = word;
    assign bus.eng_en_o     = (state == S_KICK) || (state == S_WAIT);
    assign bus.eng_length_o = len_q;
    assign bus.eng_tms_o    = tms_q;
    assign bus.eng_tdi_o    = tdi_q;
    assign bus.wr_en_o      = (state == S_STORE);
    assign bus.wr_addr_o    = word;
    assign bus.wr_data_o    = tdo_q;
    assign bus.done_o       = (state == S_FINISH);
    assign bus.err_o        = (state == S_FINISH) && err_q;

endmodule

// File: tb/tb_xvc_shift_sched.sv
// tb_xvc_shift_sched: directed bench for xvc_shift_sched with a vector
// buffer model and a shift-engine model that answers after a set delay.
// Honours XVC_SHIFT_TIMEOUT_EN to select the watchdog or stall scenario.
`define CHECK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_xvc_shift_sched;

    logic clk = 1'b0;
    logic reset_ni;

    xvc_shift_sched_if #(.C_ADDR_W(6)) bus ();

    xvc_shift_sched #(
        .C_MAX_WORDS      (64),
        .C_ADDR_W         (6),
        .C_TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stimulus-owned knobs and snapshots
    logic [31:0] tms_mem [0:63];
    logic [31:0] tdi_mem [0:63];
    int          eng_delay;
    logic        eng_mute;
    logic [31:0] tdo_base;
    int          s0, w0, d0;

    // Model-owned state and logs
    logic [5:0]  rd_addr_q = '0;
    logic        en_prev   = 1'b0;
    logic        pending   = 1'b0;
    int          cnt       = 0;
    int          start_cnt = 0;
    int          done_cnt  = 0;
    logic [31:0] len_log [$];
    logic [31:0] tms_log [$];
    logic [31:0] tdi_log [$];
    logic [5:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];

    // Buffer and engine model plus output monitor, all away from the active edge
    always @(negedge clk) begin
        bus.eng_done_i = 1'b0;
        bus.rd_tms_i   = tms_mem[rd_addr_q];
        bus.rd_tdi_i   = tdi_mem[rd_addr_q];
        rd_addr_q      = bus.rd_addr_o;
        if (bus.eng_en_o && !en_prev) begin
            start_cnt++;
            len_log.push_back(bus.eng_length_o);
            tms_log.push_back(bus.eng_tms_o);
            tdi_log.push_back(bus.eng_tdi_o);
            if (!eng_mute) begin
                pending = 1'b1;
                cnt     = eng_delay;
            end
        end else if (pending) begin
            if (!bus.eng_en_o) begin
                pending = 1'b0;
            end else begin
                cnt--;
                if (cnt == 0) begin
                    pending        = 1'b0;
                    bus.eng_done_i = 1'b1;
                    bus.eng_tdo_i  = tdo_base + 32'(start_cnt - s0 - 1);
                end
            end
        end
        if (bus.wr_en_o) begin
            wr_addr_log.push_back(bus.wr_addr_o);
            wr_data_log.push_back(bus.wr_data_o);
        end
        if (bus.done_o)
            done_cnt++;
        if ((bus.wr_en_o & bus.eng_en_o) !== 1'b0) begin
            failures++;
            $error("FAIL inv_wr_eng_excl observed=%0b expected=0", bus.wr_en_o & bus.eng_en_o);
        end
        if ((bus.err_o & !bus.done_o) !== 1'b0) begin
            failures++;
            $error("FAIL inv_err_with_done observed=%0b expected=0", bus.err_o & !bus.done_o);
        end
        if ((bus.cmd_ready_o & bus.busy_o) !== 1'b0) begin
            failures++;
            $error("FAIL inv_ready_busy_excl observed=%0b expected=0", bus.cmd_ready_o & bus.busy_o);
        end
        en_prev = bus.eng_en_o;
    end

    task automatic snap();
        s0 = start_cnt;
        w0 = wr_addr_log.size();
        d0 = done_cnt;
    endtask

    // Present one command for exactly one cycle; returns at the negedge after accept.
    task automatic issue(input logic [31:0] n);
        @(negedge clk);
        bus.cmd_nbits_i = n;
        bus.cmd_valid_i = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!bus.done_o && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        `CHECK("done_within_budget", bus.done_o, 1'b1)
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_nbits_i = '0;
        reset_ni  = 1'b0;
        eng_mute  = 1'b0;
        eng_delay = 1;
        tdo_base  = '0;
        s0 = 0; w0 = 0; d0 = 0;
        for (int i = 0; i < 64; i++) begin
            tms_mem[i] = 32'h7000_0000 | i;
            tdi_mem[i] = 32'h0B00_0000 | (i << 8);
        end
        tms_mem[0] = 32'h0000_0001;
        tdi_mem[0] = 32'hA5A5_A5A5;

        // Reset state
        #1;
        `CHECK("rst_ready", bus.cmd_ready_o, 1'b0)
        `CHECK("rst_busy", bus.busy_o, 1'b0)
        `CHECK("rst_eng_en", bus.eng_en_o, 1'b0)
        `CHECK("rst_wr_en", bus.wr_en_o, 1'b0)
        `CHECK("rst_done", bus.done_o, 1'b0)
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        #1;
        `CHECK("rst_release_ready", bus.cmd_ready_o, 1'b1)

        // One 32-bit chunk, engine answers in the first WAIT cycle:
        // FETCH, LOAD, KICK, WAIT, STORE, then FINISH five cycles after FETCH
        snap();
        tdo_base = 32'h1234_5678;
        issue(32);
        wait_done(50, cyc);
        `CHECK("c32_latency", cyc, 5)
        `CHECK("c32_err", bus.err_o, 1'b0)
        @(negedge clk);
        `CHECK("c32_starts", start_cnt - s0, 1)
        `CHECK("c32_len", len_log[s0], 32'd32)
        `CHECK("c32_tms", tms_log[s0], 32'h0000_0001)
        `CHECK("c32_tdi", tdi_log[s0], 32'hA5A5_A5A5)
        `CHECK("c32_writes", wr_addr_log.size() - w0, 1)
        `CHECK("c32_wr_addr", wr_addr_log[w0], 6'd0)
        `CHECK("c32_wr_data", wr_data_log[w0], 32'h1234_5678)
        `CHECK("c32_done_count", done_cnt - d0, 1)

        // 70 bits: chunks of 32, 32, 6; three chunks of 5 cycles each
        snap();
        tdo_base = 32'hC0DE_0000;
        issue(70);
        wait_done(100, cyc);
        `CHECK("c70_latency", cyc, 15)
        `CHECK("c70_err", bus.err_o, 1'b0)
        @(negedge clk);
        `CHECK("c70_starts", start_cnt - s0, 3)
        `CHECK("c70_len0", len_log[s0], 32'd32)
        `CHECK("c70_len1", len_log[s0+1], 32'd32)
        `CHECK("c70_len2", len_log[s0+2], 32'd6)
        `CHECK("c70_tdi1", tdi_log[s0+1], 32'h0B00_0100)
        `CHECK("c70_tms2", tms_log[s0+2], 32'h7000_0002)
        `CHECK("c70_writes", wr_addr_log.size() - w0, 3)
        `CHECK("c70_wr_addr1", wr_addr_log[w0+1], 6'd1)
        `CHECK("c70_wr_addr2", wr_addr_log[w0+2], 6'd2)
        `CHECK("c70_wr_data2", wr_data_log[w0+2], 32'hC0DE_0002)
        `CHECK("c70_done_count", done_cnt - d0, 1)

        // Zero bits: done in the cycle after the accept cycle, no activity
        snap();
        issue(0);
        `CHECK("zero_done", bus.done_o, 1'b1)
        `CHECK("zero_err", bus.err_o, 1'b0)
        repeat (3) @(negedge clk);
        `CHECK("zero_starts", start_cnt - s0, 0)
        `CHECK("zero_writes", wr_addr_log.size() - w0, 0)
        `CHECK("zero_idle", bus.busy_o, 1'b0)

        // One bit over capacity: rejected with error, no engine start
        snap();
        issue(2049);
        `CHECK("over_done", bus.done_o, 1'b1)
        `CHECK("over_err", bus.err_o, 1'b1)
        repeat (3) @(negedge clk);
        `CHECK("over_starts", start_cnt - s0, 0)
        `CHECK("over_writes", wr_addr_log.size() - w0, 0)

        // Exactly full capacity: 64 chunks of 32 bits
        snap();
        tdo_base = 32'h5500_0000;
        issue(2048);
        wait_done(400, cyc);
        `CHECK("full_latency", cyc, 320)
        `CHECK("full_err", bus.err_o, 1'b0)
        @(negedge clk);
        `CHECK("full_starts", start_cnt - s0, 64)
        `CHECK("full_len_last", len_log[s0+63], 32'd32)
        `CHECK("full_writes", wr_addr_log.size() - w0, 64)
        `CHECK("full_wr_addr_last", wr_addr_log[w0+63], 6'd63)
        `CHECK("full_wr_data_last", wr_data_log[w0+63], 32'h5500_003F)

`ifdef XVC_SHIFT_TIMEOUT_EN
        // Silent engine: 100 WAIT cycles, then abort with error and no write
        snap();
        eng_mute = 1'b1;
        issue(32);
        wait_done(200, cyc);
        `CHECK("tmo_latency", cyc, 103)
        `CHECK("tmo_err", bus.err_o, 1'b1)
        `CHECK("tmo_eng_en", bus.eng_en_o, 1'b0)
        @(negedge clk);
        `CHECK("tmo_starts", start_cnt - s0, 1)
        `CHECK("tmo_writes", wr_addr_log.size() - w0, 0)
        `CHECK("tmo_done_count", done_cnt - d0, 1)
        eng_mute = 1'b0;
`else
        // Silent engine: the block waits forever until reset
        snap();
        eng_mute = 1'b1;
        issue(70);
        repeat (300) @(negedge clk);
        `CHECK("stall_busy", bus.busy_o, 1'b1)
        `CHECK("stall_eng_en", bus.eng_en_o, 1'b1)
        `CHECK("stall_done_count", done_cnt - d0, 0)
        `CHECK("stall_writes", wr_addr_log.size() - w0, 0)
        reset_ni = 1'b0;
        @(negedge clk);
        reset_ni = 1'b1;
        eng_mute = 1'b0;
        @(negedge clk);
`endif

        // Reset during the first WAIT of a three-chunk command
        snap();
        eng_delay = 50;
        issue(70);
        repeat (8) @(negedge clk);
        `CHECK("mid_pre_eng_en", bus.eng_en_o, 1'b1)
        reset_ni = 1'b0;
        #1;
        `CHECK("mid_eng_en", bus.eng_en_o, 1'b0)
        `CHECK("mid_busy", bus.busy_o, 1'b0)
        `CHECK("mid_ready", bus.cmd_ready_o, 1'b0)
        `CHECK("mid_wr_en", bus.wr_en_o, 1'b0)
        `CHECK("mid_done", bus.done_o, 1'b0)
        `CHECK("mid_eng_length", bus.eng_length_o, 32'd0)
        `CHECK("mid_eng_tms", bus.eng_tms_o, 32'd0)
        `CHECK("mid_wr_data", bus.wr_data_o, 32'd0)
        repeat (3) @(negedge clk);
        `CHECK("mid_done_count", done_cnt - d0, 0)
        `CHECK("mid_writes", wr_addr_log.size() - w0, 0)
        reset_ni = 1'b1;
        #1;
        `CHECK("mid_release_ready", bus.cmd_ready_o, 1'b1)

        // Next command runs normally; a request raised while busy is ignored
        snap();
        eng_delay = 3;
        tdo_base  = 32'hBEEF_0000;
        issue(70);
        bus.cmd_nbits_i = 32'd32;
        bus.cmd_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        wait_done(100, cyc);
        `CHECK("post_err", bus.err_o, 1'b0)
        repeat (4) @(negedge clk);
        `CHECK("post_starts", start_cnt - s0, 3)
        `CHECK("post_len2", len_log[s0+2], 32'd6)
        `CHECK("post_writes", wr_addr_log.size() - w0, 3)
        `CHECK("post_wr_addr0", wr_addr_log[w0], 6'd0)
        `CHECK("post_wr_data2", wr_data_log[w0+2], 32'hBEEF_0002)
        `CHECK("post_done_count", done_cnt - d0, 1)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
